cu_mc: RTL and testbench
========================

# cu_mc

Parametrised multicycle control unit for the mycpu datapath, the successor to the fixed-width fetch/execute controller. It sequences instruction fetch and execute, and drives the datapath control word: PC select, register file addresses and write, bus muxes, function select, memory/IO strobes. It adds four behaviours the current controller lacks:
- generic register-address width;
- memory-ready stalls;
- a counted multi-bit shift loop;
- a resumable halt with illegal-opcode reporting.

## Interface
Parameters:
- IW, 16: instruction width; opcode is ins_in[IW-1:IW-7].
- RAW, 3: register address width; DA = ins_in[3*RAW-1:2*RAW], AA = ins_in[2*RAW-1:RAW], BA = ins_in[RAW-1:0]. Requires 3*RAW <= IW-7.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset: rst_n, asynchronous, active-low.
- ins_in  in  IW  current instruction register contents.
- z_in, n_in  in  1 each  ALU zero and negative flags.
- mem_rdy_in  in  1  memory ready; 1 = the access completes this cycle.
- resume_in  in  1  leave the halt state.
- il_out  out  1  instruction register load.
- ps_out  out  2  PC select: 00 hold, 01 increment, 10 branch, 11 jump.
- rw_out  out  1  register file write.
- rs_out  out  3*(RAW+1)  {1'b0,DA,1'b0,AA,1'b0,BA}.
- mm_out  out  1  address mux; 1 = PC.
- md_out  out  2  write-back select: 00 function unit, 01 memory, 10 IO.
- mb_out  out  1  B mux; 1 = immediate.
- fs_out  out  4  function select.
- wen_out  out  1  memory/IO write, active low.
- iom_out  out  1  IO space select.
- halted_out  out  1  in the halt state.
- ill_out  out  1  illegal opcode; one-cycle pulse in EX0.

## Operation
- Registered state: st in {RST, INF, EX0, SHF, HLT} and a shift counter cnt (RAW bits). All outputs are combinational from st, cnt, ins_in, z_in, n_in, mem_rdy_in and resume_in.
- Default control word, used unless overridden below: ps=00, il=0, rw=0, rs=0, mm=0, md=00, mb=0, fs=0000, wen=1, iom=0, halted=0, ill=0.
- RST: default word; next state INF.
- INF: il=1, mm=1. Next state is EX0 if mem_rdy_in, otherwise INF.
- EX0: rs_out carries the fields from ins_in. Behaviour by opcode (binary, 7 bits):
  - 000_ffff, register ALU op: fs=ffff, rw=1, ps=01; next INF.
  - 100_ffff, immediate ALU op: as the register ALU op, plus mb=1.
  - 001_0000, LD: md=01. While mem_rdy_in=0: ps=00, rw=0, stay in EX0. When mem_rdy_in=1: rw=1, ps=01; next INF.
  - 010_0000, ST: wen=0, held while waiting. Same stall rule as LD; ps=01 on ready.
  - 011_0000, IOR: iom=1, md=10, rw=1, ps=01.
  - 011_0001, IOW: iom=1, wen=0, ps=01.
  - 110_0000, BRZ: ps=10 if z_in, else 01.
  - 110_0001, BRN: ps=10 if n_in, else 01.
  - 111_0000, JMP: ps=11.
  - 101_000d, SHM (shift DA = AA by BA places): cnt is loaded with BA. If BA=0: ps=01, next INF, no write. Otherwise next SHF.
  - 111_1111, HALT: ps=00; next HLT.
  - Any other opcode: ill=1, ps=01; next INF.
- SHF: rw=1 and rs={0,DA,0,DA,0,BA}, so each pass shifts DA in place. fs=1110 when d=0 (left), 1101 when d=1 (right). cnt decrements every cycle. In the cycle where cnt==1: ps=01 and next INF; otherwise stay in SHF.
- HLT: halted=1 and ps=00. When resume_in=1: ps=01 that cycle; next INF.

## Timing
- Reset: all outputs take the RST default word; st=RST and cnt=0 immediately on rst_n low. The first INF follows one clk after rst_n is released.
- Single-cycle-execute instruction with mem_rdy_in held high: INF + EX0, 2 cycles.
- SHM with count N>0: 2+N cycles. SHM with count 0: 2 cycles.
- Memory stall: each low cycle of mem_rdy_in in INF or in LD/ST EX0 adds exactly one cycle, and the control word is held constant. wen_out stays low for the whole ST stall.
- Flags are sampled in the BRZ/BRN EX0 cycle only.
- rst_n asserted mid-stall, mid-SHF or in HLT aborts immediately. No write strobe (rw=1 or wen=0) may appear after the reset edge.
- resume_in is ignored outside HLT. mem_rdy_in is ignored outside INF and LD/ST EX0.

## Test plan
- Reset then ADD (000_0010, DA=1, AA=2, BA=3) with ready high:
  - RST → INF (il=1, mm=1) → EX0 (rw=1, fs=0010, rs=0001_0010_0011, ps=01).
  - Back in INF on the third cycle.
- ST with mem_rdy_in low for 3 cycles: wen=0 and ps=00 for 3 cycles, then ps=01 in the cycle mem_rdy_in rises. Repeat for LD and check md=01 with rw only on the ready cycle.
- SHM left, DA=4, count=5: exactly 5 SHF cycles with rw=1, fs=1110, rs DA=AA=4; ps=01 only on the last one. Count=0 gives no rw pulse.
- BRZ and BRN with the flag at 1 and at 0: ps=10 and 01 respectively.
- Opcode 111_1110: ill_out pulses for exactly one cycle, ps=01.
- HALT then resume_in high after 10 cycles: halted_out=1 for 10 cycles, ps=01 on resume, INF next. Also assert rst_n low during SHF and during an ST stall: outputs return to defaults at once.

Source files
------------

// File: rtl/cu_mc.sv
// Multicycle fetch/execute control unit for the mycpu datapath.
// Adds memory-ready stalls, a counted shift loop and a resumable halt.
module cu_mc #(
  parameter int IW  = 16,
  parameter int RAW = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IW-1:0]          ins_in,
  input  logic                   z_in,
  input  logic                   n_in,
  input  logic                   mem_rdy_in,
  input  logic                   resume_in,
  output logic                   il_out,
  output logic [1:0]             ps_out,
  output logic                   rw_out,
  output logic [3*(RAW+1)-1:0]   rs_out,
  output logic                   mm_out,
  output logic [1:0]             md_out,
  output logic                   mb_out,
  output logic [3:0]             fs_out,
  output logic                   wen_out,
  output logic                   iom_out,
  output logic                   halted_out,
  output logic                   ill_out
);

  localparam logic [2:0] ST_RST = 3'd0;
  localparam logic [2:0] ST_INF = 3'd1;
  localparam logic [2:0] ST_EX0 = 3'd2;
  localparam logic [2:0] ST_SHF = 3'd3;
  localparam logic [2:0] ST_HLT = 3'd4;

  localparam logic [RAW-1:0] CNT_ZERO = {RAW{1'b0}};
  localparam logic [RAW-1:0] CNT_ONE  = {{(RAW-1){1'b0}}, 1'b1};

  logic [2:0]     st_r;
  logic [2:0]     nxt_s;
  logic [RAW-1:0] cnt_r;
  logic [RAW-1:0] cnt_nxt_s;
  logic [6:0]     op_s;
  logic [RAW-1:0] da_s;
  logic [RAW-1:0] aa_s;
  logic [RAW-1:0] ba_s;

  assign op_s = ins_in[IW-1:IW-7];
  assign da_s = ins_in[3*RAW-1:2*RAW];
  assign aa_s = ins_in[2*RAW-1:RAW];
  assign ba_s = ins_in[RAW-1:0];

  // Next-state and control-word decode
  always_comb begin
    il_out     = 1'b0;
    ps_out     = 2'b00;
    rw_out     = 1'b0;
    rs_out     = {(3*(RAW+1)){1'b0}};
    mm_out     = 1'b0;
    md_out     = 2'b00;
    mb_out     = 1'b0;
    fs_out     = 4'b0000;
    wen_out    = 1'b1;
    iom_out    = 1'b0;
    halted_out = 1'b0;
    ill_out    = 1'b0;
    nxt_s      = st_r;
    cnt_nxt_s  = cnt_r;
    case (st_r)
      ST_RST: begin
        nxt_s = ST_INF;
      end
      ST_INF: begin
        il_out = 1'b1;
        mm_out = 1'b1;
        if (mem_rdy_in) begin
          nxt_s = ST_EX0;
        end else begin
          nxt_s = ST_INF;
        end
      end
      ST_EX0: begin
        rs_out = {1'b0, da_s, 1'b0, aa_s, 1'b0, ba_s};
        // Opcode groups 000 and 100 are ALU ops; the low nibble is the function
        if ((op_s[6:4] == 3'b000) || (op_s[6:4] == 3'b100)) begin
          fs_out = op_s[3:0];
          mb_out = op_s[6];
          rw_out = 1'b1;
          ps_out = 2'b01;
          nxt_s  = ST_INF;
        end else begin
          case (op_s)
            7'b0010000: begin
              md_out = 2'b01;
              if (mem_rdy_in) begin
                rw_out = 1'b1;
                ps_out = 2'b01;
                nxt_s  = ST_INF;
              end else begin
                rw_out = 1'b0;
                ps_out = 2'b00;
                nxt_s  = ST_EX0;
              end
            end
            7'b0100000: begin
              wen_out = 1'b0;
              if (mem_rdy_in) begin
                ps_out = 2'b01;
                nxt_s  = ST_INF;
              end else begin
                ps_out = 2'b00;
                nxt_s  = ST_EX0;
              end
            end
            7'b0110000: begin
              iom_out = 1'b1;
              md_out  = 2'b10;
              rw_out  = 1'b1;
              ps_out  = 2'b01;
              nxt_s   = ST_INF;
            end
            7'b0110001: begin
              iom_out = 1'b1;
              wen_out = 1'b0;
              ps_out  = 2'b01;
              nxt_s   = ST_INF;
            end
            7'b1100000: begin
              if (z_in) begin
                ps_out = 2'b10;
              end else begin
                ps_out = 2'b01;
              end
              nxt_s = ST_INF;
            end
            7'b1100001: begin
              if (n_in) begin
                ps_out = 2'b10;
              end else begin
                ps_out = 2'b01;
              end
              nxt_s = ST_INF;
            end
            7'b1110000: begin
              ps_out = 2'b11;
              nxt_s  = ST_INF;
            end
            7'b1010000, 7'b1010001: begin
              cnt_nxt_s = ba_s;
              if (ba_s == CNT_ZERO) begin
                ps_out = 2'b01;
                nxt_s  = ST_INF;
              end else begin
                ps_out = 2'b00;
                nxt_s  = ST_SHF;
              end
            end
            7'b1111111: begin
              ps_out = 2'b00;
              nxt_s  = ST_HLT;
            end
            default: begin
              ill_out = 1'b1;
              ps_out  = 2'b01;
              nxt_s   = ST_INF;
            end
          endcase
        end
      end
      ST_SHF: begin
        // DA is both source and destination so each pass shifts in place
        rw_out    = 1'b1;
        rs_out    = {1'b0, da_s, 1'b0, da_s, 1'b0, ba_s};
        cnt_nxt_s = cnt_r - CNT_ONE;
        if (op_s[0]) begin
          fs_out = 4'b1101;
        end else begin
          fs_out = 4'b1110;
        end
        if (cnt_r == CNT_ONE) begin
          ps_out = 2'b01;
          nxt_s  = ST_INF;
        end else begin
          ps_out = 2'b00;
          nxt_s  = ST_SHF;
        end
      end
      ST_HLT: begin
        halted_out = 1'b1;
        if (resume_in) begin
          ps_out = 2'b01;
          nxt_s  = ST_INF;
        end else begin
          ps_out = 2'b00;
          nxt_s  = ST_HLT;
        end
      end
      default: begin
        nxt_s = ST_RST;
      end
    endcase
  end

  // State and shift-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r  <= ST_RST;
      cnt_r <= CNT_ZERO;
    end else begin
      st_r  <= nxt_s;
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_cu_mc.sv
// Self-checking bench for cu_mc: directed vector table, multi-cycle corner
// sequences, async-reset aborts, and a randomized instruction-level model.
module tb_cu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ins;
  logic        z, n, rdy, res;
  logic        il_out, rw_out, mm_out, mb_out, wen_out, iom_out, halted_out, ill_out;
  logic [1:0]  ps_out, md_out;
  logic [11:0] rs_out;
  logic [3:0]  fs_out;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        il;
    logic [1:0]  ps;
    logic        rw;
    logic [11:0] rs;
    logic        mm;
    logic [1:0]  md;
    logic        mb;
    logic [3:0]  fs;
    logic        wen;
    logic        iom;
    logic        halted;
    logic        ill;
  } cw_t;

  typedef struct {
    logic [15:0] ins;
    logic        z;
    logic        n;
    logic        rdy;
    logic        res;
    cw_t         exp;
  } vec_t;

  vec_t tbl[$];
  vec_t q[$];
  cw_t  act;

  cu_mc #(.IW(16), .RAW(3)) dut (
    .clk(clk), .rst_n(rst_n), .ins_in(ins), .z_in(z), .n_in(n),
    .mem_rdy_in(rdy), .resume_in(res),
    .il_out(il_out), .ps_out(ps_out), .rw_out(rw_out), .rs_out(rs_out),
    .mm_out(mm_out), .md_out(md_out), .mb_out(mb_out), .fs_out(fs_out),
    .wen_out(wen_out), .iom_out(iom_out), .halted_out(halted_out), .ill_out(ill_out)
  );

  always #5 clk = ~clk;

  assign act = {il_out, ps_out, rw_out, rs_out, mm_out, md_out, mb_out, fs_out,
                wen_out, iom_out, halted_out, ill_out};

  function automatic cw_t dflt();
    cw_t c;
    c = '0;
    c.wen = 1'b1;
    return c;
  endfunction

  function automatic cw_t fet();
    cw_t c;
    c = dflt();
    c.il = 1'b1;
    c.mm = 1'b1;
    return c;
  endfunction

  function automatic cw_t ex(input logic [15:0] i, input logic [1:0] ps, input logic rw,
                             input logic [1:0] md, input logic mb, input logic [3:0] fs,
                             input logic wen, input logic iom, input logic ill);
    cw_t c;
    c = dflt();
    c.rs = {1'b0, i[8:6], 1'b0, i[5:3], 1'b0, i[2:0]};
    c.ps = ps; c.rw = rw; c.md = md; c.mb = mb; c.fs = fs;
    c.wen = wen; c.iom = iom; c.ill = ill;
    return c;
  endfunction

  function automatic cw_t shf(input logic [15:0] i, input logic last);
    cw_t c;
    c = dflt();
    c.rw = 1'b1;
    c.rs = {1'b0, i[8:6], 1'b0, i[8:6], 1'b0, i[2:0]};
    c.fs = i[9] ? 4'b1101 : 4'b1110;
    c.ps = last ? 2'b01 : 2'b00;
    return c;
  endfunction

  function automatic cw_t hlt(input logic r);
    cw_t c;
    c = dflt();
    c.halted = 1'b1;
    c.ps = r ? 2'b01 : 2'b00;
    return c;
  endfunction

  function automatic logic [15:0] mk(input logic [6:0] op, input logic [2:0] da,
                                     input logic [2:0] aa, input logic [2:0] ba);
    return {op, da, aa, ba};
  endfunction

  function automatic vec_t mv(input logic [15:0] i, input logic zz, input logic nn,
                              input logic r, input logic s, input cw_t e);
    vec_t v;
    v.ins = i; v.z = zz; v.n = nn; v.rdy = r; v.res = s; v.exp = e;
    return v;
  endfunction

  function automatic logic rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  function automatic logic legal(input logic [6:0] op);
    logic ok;
    ok = (op[6:4] == 3'b000) || (op[6:4] == 3'b100);
    case (op)
      7'b0010000, 7'b0100000, 7'b0110000, 7'b0110001, 7'b1100000,
      7'b1100001, 7'b1110000, 7'b1010000, 7'b1010001, 7'b1111111: ok = 1'b1;
      default: ok = ok;
    endcase
    return ok;
  endfunction

  task automatic push(input logic [15:0] i, input logic zz, input logic nn,
                      input logic r, input logic s, input cw_t e);
    q.push_back(mv(i, zz, nn, r, s, e));
  endtask

  task automatic check(input string name, input cw_t e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s t=%0t ins=%h got=%h want=%h", name, $time, ins, act, e);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    ins = v.ins; z = v.z; n = v.n; rdy = v.rdy; res = v.res;
    #1;
    check(name, v.exp);
  endtask

  task automatic run_q(input string name);
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      apply(v, name);
    end
  endtask

  task automatic reset_mid(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    check(name, dflt());
    @(negedge clk);
    #1;
    check(name, dflt());
    rst_n = 1'b1;
    #1;
    check(name, dflt());
  endtask

  // Expand one random instruction into its expected per-cycle control words
  task automatic gen();
    int k, s;
    logic [2:0]  da, aa, ba;
    logic [6:0]  op;
    logic [15:0] i;
    logic        f;
    k  = $urandom_range(0, 11);
    s  = $urandom_range(0, 3);
    da = 3'($urandom); aa = 3'($urandom); ba = 3'($urandom);
    case (k)
      0:  op = {3'b000, 4'($urandom)};
      1:  op = {3'b100, 4'($urandom)};
      2:  op = 7'b0010000;
      3:  op = 7'b0100000;
      4:  op = 7'b0110000;
      5:  op = 7'b0110001;
      6:  op = 7'b1100000;
      7:  op = 7'b1100001;
      8:  op = 7'b1110000;
      9:  op = {6'b101000, rb()};
      10: op = 7'b1111111;
      default: begin
        op = 7'($urandom);
        if (legal(op)) op = 7'b0011111;
      end
    endcase
    i = mk(op, da, aa, ba);
    for (int j = 0; j < s; j++) push(i, rb(), rb(), 1'b0, rb(), fet());
    push(i, rb(), rb(), 1'b1, rb(), fet());
    case (k)
      0, 1: push(i, rb(), rb(), rb(), rb(), ex(i, 2'b01, 1'b1, 2'b00, op[6], op[3:0], 1'b1, 1'b0, 1'b0));
      2: begin
        s = $urandom_range(0, 3);
        for (int j = 0; j < s; j++) push(i, rb(), rb(), 1'b0, rb(), ex(i, 2'b00, 1'b0, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0));
        push(i, rb(), rb(), 1'b1, rb(), ex(i, 2'b01, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0));
      end
      3: begin
        s = $urandom_range(0, 3);
        for (int j = 0; j < s; j++) push(i, rb(), rb(), 1'b0, rb(), ex(i, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
        push(i, rb(), rb(), 1'b1, rb(), ex(i, 2'b01, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
      end
      4: push(i, rb(), rb(), rb(), rb(), ex(i, 2'b01, 1'b1, 2'b10, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0));
      5: push(i, rb(), rb(), rb(), rb(), ex(i, 2'b01, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0));
      6: begin
        f = rb();
        push(i, f, rb(), rb(), rb(), ex(i, f ? 2'b10 : 2'b01, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0));
      end
      7: begin
        f = rb();
        push(i, rb(), f, rb(), rb(), ex(i, f ? 2'b10 : 2'b01, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0));
      end
      8: push(i, rb(), rb(), rb(), rb(), ex(i, 2'b11, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0));
      9: begin
        if (ba == 3'd0) begin
          push(i, rb(), rb(), rb(), rb(), ex(i, 2'b01, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0));
        end else begin
          push(i, rb(), rb(), rb(), rb(), ex(i, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0));
          for (int j = 1; j <= int'(ba); j++) push(i, rb(), rb(), rb(), rb(), shf(i, j == int'(ba)));
        end
      end
      10: begin
        push(i, rb(), rb(), rb(), rb(), ex(i, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0));
        s = $urandom_range(0, 4);
        for (int j = 0; j < s; j++) push(i, rb(), rb(), rb(), 1'b0, hlt(1'b0));
        push(i, rb(), rb(), rb(), 1'b1, hlt(1'b1));
      end
      default: push(i, rb(), rb(), rb(), rb(), ex(i, 2'b01, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1));
    endcase
  endtask

  initial begin
    logic [15:0] add_i, st_i, ld_i, brz_i, brn_i, ill_i, ior_i, iow_i, jmp_i, imm_i;
    logic [15:0] shl_i, shr0_i, hlt_i, shr7_i;
    cw_t c;

    rst_n = 1'b0; ins = 16'h0000; z = 1'b0; n = 1'b0; rdy = 1'b0; res = 1'b0;
    #1;
    check("reset", dflt());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_rel", dflt());

    add_i = mk(7'b0000010, 3'd1, 3'd2, 3'd3);
    st_i  = mk(7'b0100000, 3'd5, 3'd6, 3'd7);
    ld_i  = mk(7'b0010000, 3'd2, 3'd3, 3'd4);
    brz_i = mk(7'b1100000, 3'd0, 3'd1, 3'd2);
    brn_i = mk(7'b1100001, 3'd3, 3'd4, 3'd5);
    ill_i = mk(7'b1111110, 3'd7, 3'd7, 3'd1);
    ior_i = mk(7'b0110000, 3'd3, 3'd0, 3'd0);
    iow_i = mk(7'b0110001, 3'd0, 3'd4, 3'd0);
    jmp_i = mk(7'b1110000, 3'd1, 3'd1, 3'd1);
    imm_i = mk(7'b1000101, 3'd6, 3'd5, 3'd4);

    // ADD must present rs = 0001_0010_0011
    c = dflt(); c.rw = 1'b1; c.fs = 4'b0010; c.rs = 12'b0001_0010_0011; c.ps = 2'b01;
    tbl.push_back(mv(add_i, 1'b0, 1'b0, 1'b1, 1'b0, fet()));
    tbl.push_back(mv(add_i, 1'b0, 1'b0, 1'b1, 1'b0, c));
    tbl.push_back(mv(st_i, 1'b0, 1'b0, 1'b1, 1'b0, fet()));
    for (int j = 0; j < 3; j++)
      tbl.push_back(mv(st_i, 1'b0, 1'b0, 1'b0, 1'b0, ex(st_i, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mv(st_i, 1'b0, 1'b0, 1'b1, 1'b0, ex(st_i, 2'b01, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mv(ld_i, 1'b0, 1'b0, 1'b0, 1'b1, fet()));
    tbl.push_back(mv(ld_i, 1'b0, 1'b0, 1'b1, 1'b0, fet()));
    for (int j = 0; j < 3; j++)
      tbl.push_back(mv(ld_i, 1'b0, 1'b0, 1'b0, 1'b0, ex(ld_i, 2'b00, 1'b0, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(mv(ld_i, 1'b0, 1'b0, 1'b1, 1'b0, ex(ld_i, 2'b01, 1'b1, 2'b01, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(mv(brz_i, 1'b1, 1'b0, 1'b1, 1'b0, fet()));
    tbl.push_back(mv(brz_i, 1'b1, 1'b0, 1'b0, 1'b0, ex(brz_i, 2'b10, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(mv(brn_i, 1'b1, 1'b0, 1'b1, 1'b0, fet()));
    tbl.push_back(mv(brn_i, 1'b1, 1'b0, 1'b1, 1'b0, ex(brn_i, 2'b01, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(mv(brz_i, 1'b0, 1'b1, 1'b1, 1'b0, fet()));
    tbl.push_back(mv(brz_i, 1'b0, 1'b1, 1'b1, 1'b0, ex(brz_i, 2'b01, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(mv(brn_i, 1'b0, 1'b1, 1'b1, 1'b0, fet()));
    tbl.push_back(mv(brn_i, 1'b0, 1'b1, 1'b1, 1'b0, ex(brn_i, 2'b10, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(mv(ill_i, 1'b0, 1'b0, 1'b1, 1'b0, fet()));
    tbl.push_back(mv(ill_i, 1'b0, 1'b0, 1'b1, 1'b0, ex(ill_i, 2'b01, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1)));
    tbl.push_back(mv(ior_i, 1'b0, 1'b0, 1'b1, 1'b0, fet()));
    tbl.push_back(mv(ior_i, 1'b0, 1'b0, 1'b0, 1'b0, ex(ior_i, 2'b01, 1'b1, 2'b10, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0)));
    tbl.push_back(mv(iow_i, 1'b0, 1'b0, 1'b1, 1'b0, fet()));
    tbl.push_back(mv(iow_i, 1'b0, 1'b0, 1'b1, 1'b0, ex(iow_i, 2'b01, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0)));
    tbl.push_back(mv(jmp_i, 1'b0, 1'b0, 1'b1, 1'b0, fet()));
    tbl.push_back(mv(jmp_i, 1'b0, 1'b0, 1'b1, 1'b1, ex(jmp_i, 2'b11, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0)));
    tbl.push_back(mv(imm_i, 1'b0, 1'b0, 1'b1, 1'b0, fet()));
    tbl.push_back(mv(imm_i, 1'b0, 1'b0, 1'b1, 1'b0, ex(imm_i, 2'b01, 1'b1, 2'b00, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0)));
    for (int j = 0; j < tbl.size(); j++) apply(tbl[j], "tbl");

    // SHM left, DA=4, count 5; then SHM with count 0 writes nothing
    shl_i = mk(7'b1010000, 3'd4, 3'd2, 3'd5);
    push(shl_i, 1'b0, 1'b0, 1'b1, 1'b0, fet());
    push(shl_i, 1'b0, 1'b0, 1'b0, 1'b1, ex(shl_i, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0));
    for (int j = 0; j < 5; j++) begin
      c = dflt(); c.rw = 1'b1; c.rs = 12'b0100_0100_0101; c.fs = 4'b1110;
      c.ps = (j == 4) ? 2'b01 : 2'b00;
      push(shl_i, 1'b0, 1'b0, 1'b0, 1'b1, c);
    end
    shr0_i = mk(7'b1010001, 3'd3, 3'd1, 3'd0);
    push(shr0_i, 1'b0, 1'b0, 1'b1, 1'b0, fet());
    push(shr0_i, 1'b0, 1'b0, 1'b1, 1'b0, ex(shr0_i, 2'b01, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0));
    run_q("shm");

    hlt_i = mk(7'b1111111, 3'd0, 3'd0, 3'd0);
    push(hlt_i, 1'b0, 1'b0, 1'b1, 1'b0, fet());
    push(hlt_i, 1'b0, 1'b0, 1'b1, 1'b0, ex(hlt_i, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0));
    for (int j = 0; j < 10; j++) begin
      c = dflt(); c.halted = 1'b1;
      push(hlt_i, 1'b1, 1'b1, 1'b1, 1'b0, c);
    end
    c = dflt(); c.halted = 1'b1; c.ps = 2'b01;
    push(hlt_i, 1'b0, 1'b0, 1'b1, 1'b1, c);
    push(add_i, 1'b0, 1'b0, 1'b0, 1'b0, fet());
    run_q("halt");
    reset_mid("rst_inf");

    // Abort mid-SHF and mid-ST-stall
    shr7_i = mk(7'b1010001, 3'd2, 3'd3, 3'd7);
    push(shr7_i, 1'b0, 1'b0, 1'b1, 1'b0, fet());
    push(shr7_i, 1'b0, 1'b0, 1'b1, 1'b0, ex(shr7_i, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0));
    for (int j = 0; j < 3; j++) begin
      c = dflt(); c.rw = 1'b1; c.rs = 12'b0010_0010_0111; c.fs = 4'b1101;
      push(shr7_i, 1'b0, 1'b0, 1'b1, 1'b0, c);
    end
    run_q("shf_pre");
    reset_mid("rst_shf");
    push(st_i, 1'b0, 1'b0, 1'b1, 1'b0, fet());
    push(st_i, 1'b0, 1'b0, 1'b0, 1'b0, ex(st_i, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
    push(st_i, 1'b0, 1'b0, 1'b0, 1'b0, ex(st_i, 2'b00, 1'b0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0));
    run_q("st_pre");
    reset_mid("rst_st");

    for (int t = 0; t < 300; t++) begin
      gen();
      run_q("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
